ppu_oam_dma: RTL and testbench
==============================

// Module: ppu_oam_dma
// PURPOSE
//  Sprite-RAM DMA controller and sprite-RAM write-port arbiter. CPU write to $4014 with page P halts
//  the CPU and copies CPU bus $P00-$PFF into sprite RAM, starting at the current OAM address.
//  Sits between the CPU bus, the PPU register interface (its $2004 write path) and sprite RAM.
// PARAMETERS
//  DMA_REG_ADDR  16'h4014  CPU address that triggers DMA
//  XFER_LEN      256       bytes per transfer (power of two, <=256)
// PORTS
//  clk_in             in   1   PPU clock
//  rst_n_in           in   1   asynchronous, active-low reset
//  cpu_cycle_in       in   1   one-clk strobe, last PPU clk of each CPU cycle
//  cpu_addr_in        in   16  CPU address bus
//  cpu_wr_in          in   1   CPU write (valid with cpu_cycle_in)
//  cpu_data_in        in   8   CPU write data
//  dma_data_in        in   8   CPU-bus read data, valid at cpu_cycle_in of a READ cycle
//  ri_spr_ram_wr_in   in   1   $2004 write request from register interface
//  ri_spr_ram_a_in    in   8   OAM address pointer from register interface
//  ri_spr_ram_d_in    in   8   $2004 write data
//  cpu_rdy_out        out  1   0 = CPU halted
//  dma_busy_out       out  1   transfer in progress (HALT..last WRITE)
//  dma_rd_out         out  1   DMA owns CPU bus and reads
//  dma_addr_out       out  16  {page, idx}
//  spr_ram_wr_out     out  1   sprite RAM write strobe (one clk)
//  spr_ram_a_out      out  8   sprite RAM address
//  spr_ram_d_out      out  8   sprite RAM data
//  ri_drop_out        out  1   one-clk pulse: RI write discarded while busy
// BEHAVIOUR
//  Reset values: cpu_rdy_out=1, dma_busy_out=0, dma_rd_out=0, dma_addr_out=0, spr_ram_wr_out=0,
//   ri_drop_out=0, state=IDLE, idx=0, parity=0. Reset mid-transfer aborts; CPU released at once.
//  parity toggles on every cpu_cycle_in from reset; READ only when parity=0, WRITE only when parity=1.
//  All state changes occur on clk_in edges where cpu_cycle_in=1; otherwise state holds.
//  IDLE : cpu_wr_in & cpu_addr_in==DMA_REG_ADDR -> latch page=cpu_data_in, base=ri_spr_ram_a_in,
//         idx=0; -> HALT.
//  HALT : cpu_rdy_out=0. Next parity==0 -> READ, else -> ALIGN.
//  ALIGN: cpu_rdy_out=0, idle cycle -> READ.
//  READ : dma_rd_out=1, dma_addr_out={page,idx}; capture dma_data_in into data reg -> WRITE.
//  WRITE: spr_ram_a_out=base+idx (8-bit wrap), spr_ram_d_out=data reg; spr_ram_wr_out pulses on
//         the cpu_cycle_in clk. idx==XFER_LEN-1 -> IDLE (cpu_rdy_out=1 next clk), else idx++ -> READ.
//  Length: 1+512 CPU cycles if the trigger write has parity 0, 1+1+512 if parity 1.
//  Arbitration: in IDLE, spr_ram_* = ri_spr_ram_* (combinational pass-through). While busy, DMA
//   owns the port; any ri_spr_ram_wr_in is dropped and pulses ri_drop_out.
//  $4014 writes while busy are ignored (no retrigger). base+idx wraps $FF->$00; the RI pointer is
//   not modified (after 256 writes it equals base again).
//  Trigger on same clk as an RI $2004 write: RI write passes through (still IDLE), base samples
//   pre-increment pointer.
// STRUCTURE
//  ppu_pkg: dma_state_t enum {IDLE,HALT,ALIGN,READ,WRITE}, PPU_OAM_DMA_ADDR=16'h4014.
//  Sub-module: ppu_spr_port_mux (combinational 2:1 sprite-RAM port mux + drop detect).
//  Single always_ff with async clear for state/idx/page/base/data/parity; next-state in always_comb.
// TESTING
//  1. Write $02 to $4014 at parity 0, base=$00 -> cpu_rdy_out low 513 CPU cycles; OAM[i]=mem[$0200+i].
//  2. Same at parity 1 -> 514 cycles; one ALIGN cycle before first dma_rd_out; data identical.
//  3. base=$F0 -> first write to OAM $F0, byte $10 lands at $00, last at $EF; no write lost.
//  4. Second $4014 write and $2004 write mid-DMA -> no retrigger, ri_drop_out pulses, OAM unchanged.
//  5. Assert rst_n_in during READ idx=$40 -> cpu_rdy_out=1, busy=0 immediately; no further writes.
//  6. IDLE $2004 writes $11,$22 at ptr $05 -> spr_ram_wr_out with a=$05,d=$11 then a=$06,d=$22.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite-RAM DMA block.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] PPU_OAM_DMA_ADDR = 16'h4014;
  localparam int          PPU_OAM_XFER_LEN = 256;

endpackage

// File: rtl/ppu_spr_port_mux.sv
// Sprite-RAM write port: DMA owns the port while busy, otherwise the $2004 path passes through.
module ppu_spr_port_mux (
  input  logic       dma_own_in,
  input  logic       dma_wr_in,
  input  logic [7:0] dma_a_in,
  input  logic [7:0] dma_d_in,
  input  logic       ri_wr_in,
  input  logic [7:0] ri_a_in,
  input  logic [7:0] ri_d_in,
  output logic       wr_out,
  output logic [7:0] a_out,
  output logic [7:0] d_out,
  output logic       drop_out
);

  assign wr_out   = dma_own_in ? dma_wr_in : ri_wr_in;
  assign a_out    = dma_own_in ? dma_a_in  : ri_a_in;
  assign d_out    = dma_own_in ? dma_d_in  : ri_d_in;
  // A $2004 write that arrives while DMA owns the port is lost; flag it.
  assign drop_out = dma_own_in & ri_wr_in;

endmodule

// File: rtl/ppu_oam_dma.sv
// $4014 sprite DMA: halts the CPU and copies one CPU page into sprite RAM starting at the OAM pointer.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = PPU_OAM_DMA_ADDR,
  parameter int          XFER_LEN     = PPU_OAM_XFER_LEN
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cpu_cycle_in,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  dma_data_in,
  input  logic        ri_spr_ram_wr_in,
  input  logic [7:0]  ri_spr_ram_a_in,
  input  logic [7:0]  ri_spr_ram_d_in,
  output logic        cpu_rdy_out,
  output logic        dma_busy_out,
  output logic        dma_rd_out,
  output logic [15:0] dma_addr_out,
  output logic        spr_ram_wr_out,
  output logic [7:0]  spr_ram_a_out,
  output logic [7:0]  spr_ram_d_out,
  output logic        ri_drop_out
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] base_q, base_d;
  logic [7:0] data_q, data_d;
  logic       parity_q;

  logic       dma_own;
  logic       dma_wr;
  logic [7:0] dma_a;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      page_q   <= '0;
      base_q   <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      base_q   <= base_d;
      data_q   <= data_d;
      parity_q <= parity_q ^ cpu_cycle_in;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    base_d  = base_q;
    data_d  = data_q;
    if (cpu_cycle_in) begin
      case (state_q)
        IDLE: begin
          if (cpu_wr_in && (cpu_addr_in == DMA_REG_ADDR)) begin
            page_d  = cpu_data_in;
            base_d  = ri_spr_ram_a_in;
            idx_d   = '0;
            state_d = HALT;
          end
        end
        // The cycle after HALT has the opposite parity; reads must land on parity 0.
        HALT:  state_d = parity_q ? READ : ALIGN;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = dma_data_in;
          state_d = WRITE;
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rdy_out  = (state_q == IDLE);
    dma_busy_out = (state_q != IDLE);
    dma_own      = (state_q != IDLE);
    dma_rd_out   = (state_q == READ);
    dma_addr_out = (state_q == READ) ? {page_q, idx_q} : 16'h0000;
    dma_wr       = (state_q == WRITE) && cpu_cycle_in;
    // OAM destination wraps within the 256-byte sprite RAM.
    dma_a        = base_q + idx_q;
  end

  ppu_spr_port_mux u_port_mux (
    .dma_own_in (dma_own),
    .dma_wr_in  (dma_wr),
    .dma_a_in   (dma_a),
    .dma_d_in   (data_q),
    .ri_wr_in   (ri_spr_ram_wr_in),
    .ri_a_in    (ri_spr_ram_a_in),
    .ri_d_in    (ri_spr_ram_d_in),
    .wr_out     (spr_ram_wr_out),
    .a_out      (spr_ram_a_out),
    .d_out      (spr_ram_d_out),
    .drop_out   (ri_drop_out)
  );

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Bench for ppu_oam_dma: table-driven and randomized transfers against a page-copy reference model.
module tb_ppu_oam_dma;

  localparam int XFER = 256;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cpu_cycle_in;
  logic [15:0] cpu_addr_in;
  logic        cpu_wr_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  dma_data_in;
  logic        ri_spr_ram_wr_in;
  logic [7:0]  ri_spr_ram_a_in;
  logic [7:0]  ri_spr_ram_d_in;
  logic        cpu_rdy_out;
  logic        dma_busy_out;
  logic        dma_rd_out;
  logic [15:0] dma_addr_out;
  logic        spr_ram_wr_out;
  logic [7:0]  spr_ram_a_out;
  logic [7:0]  spr_ram_d_out;
  logic        ri_drop_out;

  always #5 clk_in = ~clk_in;

  ppu_oam_dma dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .cpu_cycle_in     (cpu_cycle_in),
    .cpu_addr_in      (cpu_addr_in),
    .cpu_wr_in        (cpu_wr_in),
    .cpu_data_in      (cpu_data_in),
    .dma_data_in      (dma_data_in),
    .ri_spr_ram_wr_in (ri_spr_ram_wr_in),
    .ri_spr_ram_a_in  (ri_spr_ram_a_in),
    .ri_spr_ram_d_in  (ri_spr_ram_d_in),
    .cpu_rdy_out      (cpu_rdy_out),
    .dma_busy_out     (dma_busy_out),
    .dma_rd_out       (dma_rd_out),
    .dma_addr_out     (dma_addr_out),
    .spr_ram_wr_out   (spr_ram_wr_out),
    .spr_ram_a_out    (spr_ram_a_out),
    .spr_ram_d_out    (spr_ram_d_out),
    .ri_drop_out      (ri_drop_out)
  );

  // CPU bus memory contents: odd multiplier on the low byte keeps every byte of a page distinct.
  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    return 8'((int'(a[15:8]) * 37) + (int'(a[7:0]) * 11) + 3);
  endfunction

  // Bus model: answers DMA reads; a recognisable filler otherwise.
  assign dma_data_in = dma_rd_out ? bus_byte(dma_addr_out) : 8'hA5;

  function automatic int model_halt_cycles(input bit par);
    return 1 + int'(par) + 2 * XFER;
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] oam [256];
  logic [7:0] exp_oam [256];
  wr_t        wlog [$];
  int         halt_cnt, rd_cnt, drop_cnt, first_rd, ncyc;
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk_in) begin
    if (spr_ram_wr_out) begin
      oam[spr_ram_a_out] = spr_ram_d_out;
      wlog.push_back({spr_ram_a_out, spr_ram_d_out});
    end
    if (ri_drop_out) drop_cnt++;
    if (cpu_cycle_in) begin
      if (!cpu_rdy_out) halt_cnt++;
      if (dma_rd_out) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = ncyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU cycle = three PPU clocks, strobe on the last.
  task automatic cpu_cyc(input logic [15:0] a, input logic w, input logic [7:0] d,
                         input logic rw, input logic [7:0] rd);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    cpu_addr_in      = a;
    cpu_wr_in        = w;
    cpu_data_in      = d;
    ri_spr_ram_wr_in = rw;
    ri_spr_ram_d_in  = rd;
    cpu_cycle_in     = 1'b1;
    @(posedge clk_in); #1;
    cpu_cycle_in     = 1'b0;
    cpu_wr_in        = 1'b0;
    ri_spr_ram_wr_in = 1'b0;
    cpu_addr_in      = 16'h0000;
    ncyc++;
  endtask

  task automatic idle_cyc();
    cpu_cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic run_dma(input logic [7:0] page, input logic [7:0] base, input bit par,
                         input bit trig_ri, input bit mid, input int exp_halt, input int exp_off);
    int trig, off, bad, nw;
    bit done;
    if ((ncyc % 2) != int'(par)) idle_cyc();
    ri_spr_ram_a_in = base;
    wlog.delete();
    halt_cnt = 0; rd_cnt = 0; drop_cnt = 0; first_rd = -1;
    for (int i = 0; i < XFER; i++) exp_oam[8'(int'(base) + i)] = bus_byte({page, 8'(i)});
    trig = ncyc;
    cpu_cyc(16'h4014, 1'b1, page, trig_ri, 8'h77);
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      if (mid && k == 100) cpu_cyc(16'h4014, 1'b1, page ^ 8'h33, 1'b1, 8'hEE);
      else idle_cyc();
      if (!dma_busy_out) done = 1'b1;
    end
    chk("dma_done", 32'(done), 32'd1);
    chk("halt_cycles", halt_cnt, exp_halt);
    chk("first_read_offset", first_rd - trig, exp_off);
    chk("read_count", rd_cnt, XFER);
    off = trig_ri ? 1 : 0;
    chk("write_count", wlog.size(), XFER + off);
    if (trig_ri && wlog.size() > 0) chk("ri_trigger_passthru", 32'(wlog[0]), {16'h0, base, 8'h77});
    bad = 0;
    for (int i = 0; i < XFER; i++)
      if (wlog.size() > i + off) begin
        if (wlog[i + off].a !== 8'(int'(base) + i)) bad++;
      end else bad++;
    chk("write_order", bad, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== exp_oam[i]) bad++;
    chk("oam_content", bad, 0);
    chk("ri_drop_count", drop_cnt, mid ? 1 : 0);
    chk("cpu_rdy_after", 32'(cpu_rdy_out), 32'd1);
    nw = wlog.size();
    repeat (3) idle_cyc();
    chk("no_retrigger", 32'(dma_busy_out), 32'd0);
    chk("no_extra_writes", wlog.size(), nw);
  endtask

  typedef struct {
    logic [7:0] page;
    logic [7:0] base;
    bit         par;
    bit         trig_ri;
    bit         mid;
    int         exp_halt;
    int         exp_off;
  } vec_t;

  vec_t vt [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    vt[0] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 513, 2};
    vt[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 514, 3};
    vt[2] = '{8'h80, 8'hF0, 1'b0, 1'b0, 1'b0, 513, 2};
    vt[3] = '{8'h3C, 8'h9A, 1'b1, 1'b0, 1'b1, 514, 3};
    vt[4] = '{8'h41, 8'h20, 1'b0, 1'b1, 1'b0, 513, 2};

    rst_n_in = 1'b0; cpu_cycle_in = 1'b0; cpu_addr_in = '0; cpu_wr_in = 1'b0;
    cpu_data_in = '0; ri_spr_ram_wr_in = 1'b0; ri_spr_ram_a_in = '0; ri_spr_ram_d_in = '0;
    ncyc = 0; halt_cnt = 0; rd_cnt = 0; drop_cnt = 0; first_rd = -1;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    #1;
    chk("reset_cpu_rdy", 32'(cpu_rdy_out), 32'd1);
    chk("reset_busy", 32'(dma_busy_out), 32'd0);
    chk("reset_rd", 32'(dma_rd_out), 32'd0);
    chk("reset_addr", 32'(dma_addr_out), 32'd0);
    chk("reset_spr_wr", 32'(spr_ram_wr_out), 32'd0);
    chk("reset_drop", 32'(ri_drop_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    ncyc = 0;

    for (int v = 0; v < 5; v++) begin
      run_dma(vt[v].page, vt[v].base, vt[v].par, vt[v].trig_ri, vt[v].mid,
              vt[v].exp_halt, vt[v].exp_off);
      if (vt[v].base == 8'hF0) begin
        chk("wrap_byte10_at_00", 32'(oam[0]), 32'(bus_byte({vt[v].page, 8'h10})));
        chk("wrap_last_at_EF", 32'(oam[8'hEF]), 32'(bus_byte({vt[v].page, 8'hFF})));
      end
    end

    for (int r = 0; r < 3; r++) begin
      logic [7:0] pg, bs;
      bit pr, tr;
      pg = 8'($urandom);
      bs = 8'($urandom);
      pr = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      run_dma(pg, bs, pr, tr, 1'b0, model_halt_cycles(pr), 2 + int'(pr));
    end

    // Reset in the middle of a transfer.
    ri_spr_ram_a_in = 8'h10;
    wlog.delete();
    cpu_cyc(16'h4014, 1'b1, 8'h05, 1'b0, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      idle_cyc();
      if (dma_rd_out && dma_addr_out == 16'h0540) found = 1'b1;
    end
    chk("reach_read_idx40", 32'(found), 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("midreset_cpu_rdy", 32'(cpu_rdy_out), 32'd1);
    chk("midreset_busy", 32'(dma_busy_out), 32'd0);
    chk("midreset_rd", 32'(dma_rd_out), 32'd0);
    chk("midreset_addr", 32'(dma_addr_out), 32'd0);
    chk("writes_before_reset", wlog.size(), 64);
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    ncyc = 0;
    repeat (10) idle_cyc();
    chk("no_writes_after_reset", wlog.size(), 64);
    chk("idle_after_reset", 32'(dma_busy_out), 32'd0);

    // $2004 pass-through while idle.
    wlog.delete();
    ri_spr_ram_a_in = 8'h05;
    cpu_cyc(16'h0000, 1'b0, 8'h00, 1'b1, 8'h11);
    ri_spr_ram_a_in = 8'h06;
    cpu_cyc(16'h0000, 1'b0, 8'h00, 1'b1, 8'h22);
    chk("ri_write_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("ri_write0", 32'(wlog[0]), 32'h0511);
      chk("ri_write1", 32'(wlog[1]), 32'h0622);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
